scene_sequencer: RTL and testbench
==================================

// Module: scene_sequencer
// PURPOSE
//   Frame-rate scheduler that drives the demoscene VGA colour/pattern selector.
//   Counts frames from the VGA timing generator's vsync, holds each scene for a programmable time,
//   fades brightness down, switches scene index, and fades back up. Also honours a "next" button.
//   Sits between the VGA timing block (vsync source) and the pixel colour mux (consumes scene/fade).
// PARAMETERS
//   SCENE_FRAMES     180  frames a scene is held at full brightness (>=2)
//   FADE_FRAMES      4    frames per fade step; 3 steps per fade direction (>=1)
//   NUM_SCENES       4    number of scenes, scene index wraps NUM_SCENES-1 -> 0 (2..4)
//   DEBOUNCE_FRAMES  2    consecutive frame samples btn_next must read 1 to count as a press (>=1)
// PORTS
//   clk            in   1  pixel clock
//   rst            in   1  synchronous, active-high reset
//   vsync          in   1  VGA vsync, active low, from timing generator (same clk domain)
//   btn_next       in   1  raw asynchronous push button, active high
//   pause          in   1  1 = freeze automatic scene timer (button still works)
//   scene          out  2  current scene index, drives colour mux select
//   fade           out  2  brightness level, 3 = full, 0 = black
//   scene_changed  out  1  one-cycle pulse in the cycle scene updates
//   busy           out  1  1 while a transition (fade out/switch/fade in) is in progress
// BEHAVIOUR
//   Reset: one clk, synchronous, active-high. scene=0, fade=3, scene_changed=0, busy=0,
//     state=HOLD, hold/step counters=0, button pending=0, sync/debounce regs=0 (vsync sync regs=1).
//     Reset asserted mid-transition aborts it; outputs show reset values the cycle after rst sampled high.
//   frame_tick: vsync through 2-FF sync, 1-cycle pulse on synced 1->0 edge. All counting uses frame_tick.
//   Button: btn_next 2-FF synced; sampled only on frame_tick; after a 0 sample, DEBOUNCE_FRAMES
//     consecutive 1 samples set pending=1 (single flag, extra presses while pending are dropped).
//     Re-arm requires a 0 sample. pending cleared on HOLD->FADE_OUT.
//   States (busy = state!=HOLD):
//     HOLD:     on frame_tick with pause=0, hold_cnt++. Go FADE_OUT when (tick && hold_cnt==SCENE_FRAMES-1
//               && pause=0) or pending=1; hold_cnt<=0 on exit. pause=1 freezes hold_cnt (no clear).
//     FADE_OUT: step_cnt counts ticks 0..FADE_FRAMES-1; at wrap fade--. When fade reaches 0 and a further
//               FADE_FRAMES ticks elapse -> SWITCH? No: go SWITCH on the tick that writes fade=0.
//     SWITCH:   exactly one clk: scene <= (scene==NUM_SCENES-1) ? 0 : scene+1; scene_changed=1; -> FADE_IN.
//     FADE_IN:  same step timing, fade++; on the tick that writes fade=3 -> HOLD (hold_cnt=0).
//   Latency: fade-out = 3*FADE_FRAMES ticks, switch = 1 clk, fade-in = 3*FADE_FRAMES ticks.
//   pending set during FADE_OUT/SWITCH/FADE_IN is honoured on first HOLD cycle (one extra transition).
//   Simultaneous timer expiry and pending: single transition, pending cleared.
//   frame_tick and button-sample on same cycle as state exit: sample still processed.
//   hold_cnt width $clog2(SCENE_FRAMES), step_cnt width $clog2(FADE_FRAMES)+1; never exceed max-1.
//   Illegal state encoding -> HOLD next cycle, outputs keep values.
// STRUCTURE
//   Shared package demo_pkg: state encodings (HOLD/FADE_OUT/SWITCH/FADE_IN), FADE_MAX=2'd3,
//     scene index width constant, reused by VGA colour mux.
//   Sub-module btn_debounce: 2-FF sync + frame-sampled debounce, output one-cycle press pulse.
//   Top: vsync edge detector, FSM, counters, registered outputs (no combinational output paths).
// TESTING (SCENE_FRAMES=4, FADE_FRAMES=2, NUM_SCENES=4, DEBOUNCE_FRAMES=2 unless noted)
//   Auto advance: 4 vsync falls idle -> busy=1, fade 3,2,1,0 every 2 ticks, scene 0->1 with 1-clk
//     scene_changed, fade 1,2,3 every 2 ticks, busy=0 after 12 ticks + 1 clk.
//   Wrap: run 4 transitions -> scene 0,1,2,3,0; exactly 4 scene_changed pulses.
//   Pause: pause=1 for 20 ticks -> scene stays 0, fade=3, busy=0; btn press (2 ticks high) still transitions.
//   Debounce: btn high for 1 tick only -> no transition; high 2 ticks -> pending, transition starts next HOLD cycle.
//   Queueing: two separate presses during FADE_IN -> exactly one extra transition after return to HOLD.
//   Reset mid-FADE_OUT (fade=1): rst 1 clk -> scene=0, fade=3, busy=0, scene_changed=0; timer restarts from 0.

Source files
------------

// File: rtl/demo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : demo_pkg
// Description : Shared definitions for the demoscene video path. It holds
//               the scene sequencer state encodings, the brightness range and
//               the scene index width. The VGA colour mux uses the same
//               constants, so both sides agree on the scene/fade encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package demo_pkg;

  localparam int SCENE_W = 2;
  localparam int FADE_W  = 2;

  localparam logic [FADE_W-1:0] FADE_MAX = 2'd3;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  // Advance the scene index and wrap after the last scene.
  function automatic logic [SCENE_W-1:0] next_scene(
    input logic [SCENE_W-1:0] cur,
    input logic [SCENE_W-1:0] last
  );
    return (cur == last) ? '0 : cur + SCENE_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scene_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : scene_sequencer_if
// Description : Bundles the signals between the timing/button side and the
//               scene sequencer.
//   vsync, btn_next, pause : driven by the master (timing gen / panel)
//   scene, fade            : current scene index and brightness level
//   scene_changed, busy    : pulse on scene update / transition in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface scene_sequencer_if;
  import demo_pkg::*;

  logic               vsync;
  logic               btn_next;
  logic               pause;
  logic [SCENE_W-1:0] scene;
  logic [FADE_W-1:0]  fade;
  logic               scene_changed;
  logic               busy;

  modport master (
    output vsync, btn_next, pause,
    input  scene, fade, scene_changed, busy
  );

  modport slave (
    input  vsync, btn_next, pause,
    output scene, fade, scene_changed, busy
  );

endinterface
`default_nettype wire

// File: rtl/scene_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises the raw push button and debounces it at frame
//               rate. After a 0 sample, DEBOUNCE_FRAMES consecutive 1 samples
//               produce a single one-cycle press pulse. A new press needs a 0
//               sample first.
//   clk, rst   : clock, synchronous active-high reset
//   frame_tick : one-cycle pulse per frame, sampling strobe
//   btn        : raw asynchronous button, active high
//   press      : one-cycle pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (frame_tick) begin
        if (!r_sync2) begin
          // A released sample re-arms detection and restarts the run.
          r_armed <= 1'b1;
          r_cnt   <= '0;
        end else if (r_armed) begin
          if (r_cnt == CNT_LAST) begin
            r_press <= 1'b1;
            r_armed <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scene_sequencer
// Description : Frame-rate scene scheduler for the demoscene colour mux.
//               It holds each scene for SCENE_FRAMES frames, then fades down
//               in three steps, switches the scene index and fades back up.
//               A debounced "next" press forces an early transition.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : slave side of scene_sequencer_if (vsync, btn_next, pause in;
//              scene, fade, scene_changed, busy out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module scene_sequencer
  import demo_pkg::*;
#(
  parameter int SCENE_FRAMES    = 180,
  parameter int FADE_FRAMES     = 4,
  parameter int NUM_SCENES      = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  scene_sequencer_if.slave   bus
);

  localparam int                 HOLD_W     = $clog2(SCENE_FRAMES);
  localparam int                 STEP_W     = $clog2(FADE_FRAMES) + 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SCENE_FRAMES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  logic               r_vs_sync1;
  logic               r_vs_sync2;
  logic               r_vs_prev;
  seq_state_t         r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [STEP_W-1:0]  r_step_cnt;
  logic               r_pending;
  logic [SCENE_W-1:0] r_scene;
  logic [FADE_W-1:0]  r_fade;
  logic               r_scene_changed;
  logic               r_busy;

  logic w_frame_tick;
  logic w_press;
  logic w_timer_done;
  logic w_start;

  // Falling edge of the synchronised vsync marks one frame.
  assign w_frame_tick = r_vs_prev & ~r_vs_sync2;

  btn_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_btn_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (w_frame_tick),
    .btn        (bus.btn_next),
    .press      (w_press)
  );

  assign w_timer_done = w_frame_tick & ~bus.pause & (r_hold_cnt == HOLD_LAST);
  assign w_start      = (r_state == HOLD) & (r_pending | w_timer_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_sync1      <= 1'b1;
      r_vs_sync2      <= 1'b1;
      r_vs_prev       <= 1'b1;
      r_state         <= HOLD;
      r_hold_cnt      <= '0;
      r_step_cnt      <= '0;
      r_pending       <= 1'b0;
      r_scene         <= '0;
      r_fade          <= FADE_MAX;
      r_scene_changed <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_vs_sync1      <= bus.vsync;
      r_vs_sync2      <= r_vs_sync1;
      r_vs_prev       <= r_vs_sync2;
      r_scene_changed <= 1'b0;

      // Single pending flag. When a transition starts it consumes the flag;
      // a press landing in that same cycle only survives if nothing was
      // already pending, so a held-over press never causes two transitions.
      if (w_start) begin
        r_pending <= w_press & ~r_pending;
      end else if (w_press) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        HOLD: begin
          if (w_start) begin
            r_state    <= FADE_OUT;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_step_cnt <= '0;
          end else if (w_frame_tick && !bus.pause) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        FADE_OUT: begin
          if (w_frame_tick) begin
            if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              r_fade     <= r_fade - 2'd1;
              if (r_fade == 2'd1) begin
                r_state <= SWITCH;
              end
            end else begin
              r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
          end
        end

        SWITCH: begin
          r_scene         <= next_scene(r_scene, SCENE_LAST);
          r_scene_changed <= 1'b1;
          r_state         <= FADE_IN;
        end

        FADE_IN: begin
          if (w_frame_tick) begin
            if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              r_fade     <= r_fade + 2'd1;
              if (r_fade == FADE_MAX - 2'd1) begin
                r_state    <= HOLD;
                r_busy     <= 1'b0;
                r_hold_cnt <= '0;
              end
            end else begin
              r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
          end
        end

        default: begin
          r_state <= HOLD;
        end
      endcase
    end
  end

  assign bus.scene         = r_scene;
  assign bus.fade          = r_fade;
  assign bus.scene_changed = r_scene_changed;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_sequencer
// Description : Self-checking bench for scene_sequencer. Each expected
//               transition pushes its fade steps and new scene index onto a
//               queue; a monitor pops an entry whenever the DUT changes fade
//               or pulses scene_changed and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  scene_sequencer_if bus ();

  scene_sequencer #(
    .SCENE_FRAMES    (4),
    .FADE_FRAMES     (2),
    .NUM_SCENES      (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         exp_q[$];
  bit         mon_en   = 1'b0;
  logic [1:0] prev_fade = 2'd3;
  logic       prev_sc   = 1'b0;
  int         sc_count  = 0;
  int         sc_base;

  task automatic check_value(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Fade events are encoded as the level, scene events as 16 + index.
  task automatic sb_pop(input string tag, input int observed);
    if (exp_q.size() == 0) begin
      check_value({tag, "_unexpected"}, observed, -1);
    end else begin
      check_value(tag, observed, exp_q.pop_front());
    end
  endtask

  task automatic push_transition(input int new_scene);
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(16 + new_scene);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.fade !== prev_fade) begin
        sb_pop("fade_step", int'(bus.fade));
      end
      if (bus.scene_changed === 1'b1) begin
        sc_count++;
        check_value("sc_pulse_width", int'(prev_sc), 0);
        sb_pop("scene_step", 16 + int'(bus.scene));
      end
    end
    prev_fade <= bus.fade;
    prev_sc   <= bus.scene_changed;
  end

  task automatic frame();
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  initial begin
    bus.vsync    = 1'b1;
    bus.btn_next = 1'b0;
    bus.pause    = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_value("rst_scene", int'(bus.scene), 0);
    check_value("rst_fade", int'(bus.fade), 3);
    check_value("rst_sc", int'(bus.scene_changed), 0);
    check_value("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    mon_en = 1'b1;

    // Automatic advance after four frames.
    push_transition(1);
    frames(3);
    check_value("auto_pre_busy", int'(bus.busy), 0);
    frame();
    check_value("auto_start_busy", int'(bus.busy), 1);
    check_value("auto_start_fade", int'(bus.fade), 3);
    frames(11);
    check_value("auto_mid_busy", int'(bus.busy), 1);
    frame();
    check_value("auto_end_busy", int'(bus.busy), 0);
    check_value("auto_end_scene", int'(bus.scene), 1);
    check_value("auto_end_fade", int'(bus.fade), 3);

    // Wrap through the remaining scenes back to 0.
    push_transition(2);
    push_transition(3);
    push_transition(0);
    frames(48);
    check_value("wrap_scene", int'(bus.scene), 0);
    check_value("wrap_busy", int'(bus.busy), 0);
    check_value("wrap_sc_count", sc_count, 4);

    // Pause freezes the timer but the button still works.
    bus.pause = 1'b1;
    frames(20);
    check_value("pause_scene", int'(bus.scene), 0);
    check_value("pause_fade", int'(bus.fade), 3);
    check_value("pause_busy", int'(bus.busy), 0);
    push_transition(1);
    bus.btn_next = 1'b1;
    frames(2);
    bus.btn_next = 1'b0;
    check_value("pause_btn_busy", int'(bus.busy), 1);
    frames(12);
    check_value("pause_btn_done", int'(bus.busy), 0);
    check_value("pause_btn_scene", int'(bus.scene), 1);

    // A single high sample is rejected; two consecutive are a press.
    bus.btn_next = 1'b1;
    frame();
    bus.btn_next = 1'b0;
    frames(3);
    check_value("db_short_busy", int'(bus.busy), 0);
    check_value("db_short_scene", int'(bus.scene), 1);
    push_transition(2);
    bus.btn_next = 1'b1;
    frames(2);
    bus.btn_next = 1'b0;
    check_value("db_long_busy", int'(bus.busy), 1);
    frames(12);
    check_value("db_long_done", int'(bus.busy), 0);
    check_value("db_long_scene", int'(bus.scene), 2);

    // Two presses during fade-in queue exactly one extra transition.
    sc_base = sc_count;
    push_transition(3);
    push_transition(0);
    bus.btn_next = 1'b1;
    frames(2);
    bus.btn_next = 1'b0;
    frames(6);
    check_value("q_switched_scene", int'(bus.scene), 3);
    check_value("q_fadein_busy", int'(bus.busy), 1);
    bus.btn_next = 1'b1;
    frames(2);
    bus.btn_next = 1'b0;
    frame();
    bus.btn_next = 1'b1;
    frames(2);
    bus.btn_next = 1'b0;
    frame();
    check_value("q_extra_busy", int'(bus.busy), 1);
    check_value("q_extra_fade", int'(bus.fade), 3);
    frames(12);
    check_value("q_extra_done", int'(bus.busy), 0);
    check_value("q_extra_scene", int'(bus.scene), 0);
    frames(8);
    check_value("q_no_third_busy", int'(bus.busy), 0);
    check_value("q_sc_count", sc_count - sc_base, 2);

    // Reset in the middle of fade-out aborts the transition.
    bus.pause = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(1);
    frames(8);
    check_value("mid_fade", int'(bus.fade), 1);
    check_value("mid_busy", int'(bus.busy), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("mrst_scene", int'(bus.scene), 0);
    check_value("mrst_fade", int'(bus.fade), 3);
    check_value("mrst_sc", int'(bus.scene_changed), 0);
    check_value("mrst_busy", int'(bus.busy), 0);
    check_value("mrst_sb_drained", exp_q.size(), 0);
    @(negedge clk);
    mon_en = 1'b1;
    push_transition(1);
    frames(3);
    check_value("mrst_timer_pre", int'(bus.busy), 0);
    frame();
    check_value("mrst_timer_start", int'(bus.busy), 1);
    frames(12);
    check_value("mrst_done_busy", int'(bus.busy), 0);
    check_value("mrst_done_scene", int'(bus.scene), 1);

    check_value("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
